conv11_input_packer: RTL and testbench

- Ingress stage of the 1x1 convolution path; feeds the compute module.
- Accepts a serial activation stream, one channel value per beat, channel-major per pixel.
- Packs IN_CH beats into one per-pixel channel vector and queues it in a small FIFO.
- Presents vectors to compute over a valid/ready handshake and tracks pixel count per frame.

---
 rtl/conv11_input_packer.sv | 158 +++++++++++++++
 tb/tb_conv11_input_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv11_input_packer.sv
// Serial-to-vector ingress packer for the 1x1 conv path, with vector FIFO.
// Optional per-frame last-beat marker: define CONV11_INPUT_LAST_EN.
module conv11_input_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int IN_CH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_PIX    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
`ifdef CONV11_INPUT_LAST_EN
  input  logic                      in_last,
  output logic                      out_last,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_CH*IN_WIDTH-1:0] out_data,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int CW = $clog2(IN_CH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int XW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int VW = IN_CH * IN_WIDTH;
  localparam int SW = (IN_CH - 1) * IN_WIDTH;

  localparam logic [CW-1:0] CH_LAST  = CW'(IN_CH - 1);
  localparam logic [PW:0]   FULL     = (PW+1)'(FIFO_DEPTH);
  localparam logic [XW-1:0] PIX_LAST = XW'(NUM_PIX - 1);

  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [VW-1:0] mem_q [FIFO_DEPTH];
  logic [VW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [XW-1:0] pix_cnt_q, pix_cnt_d;
  logic          frame_done_q, frame_done_d;

  logic          beat_last, head_last;
  logic          full, at_last;
  logic          accept, push, pop;
  logic [VW-1:0] vec;

`ifdef CONV11_INPUT_LAST_EN
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  assign beat_last = in_last;
  assign head_last = last_q[rd_ptr_q];
  assign out_last  = out_valid && head_last;
`else
  assign beat_last = 1'b0;
  assign head_last = 1'b0;
`endif

  assign full       = (count_q == FULL);
  assign at_last    = (ch_cnt_q == CH_LAST);
  // Only a vector-completing beat needs FIFO room.
  assign in_ready   = !full || (!at_last && !beat_last);
  assign accept     = in_valid && in_ready;
  assign push       = accept && (at_last || beat_last);
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (ch_cnt_q != '0) || out_valid;
  assign frame_done = frame_done_q;

  // Lanes above the current beat are zero-filled for early-terminated vectors.
  always_comb begin
    vec = '0;
    for (int k = 0; k < IN_CH - 1; k++) begin
      if (CW'(k) < ch_cnt_q) begin
        vec[k*IN_WIDTH +: IN_WIDTH] = stage_q[k*IN_WIDTH +: IN_WIDTH];
      end
    end
    for (int k = 0; k < IN_CH; k++) begin
      if (ch_cnt_q == CW'(k)) begin
        vec[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    ch_cnt_d     = ch_cnt_q;
    stage_d      = stage_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
`ifdef CONV11_INPUT_LAST_EN
    last_d       = last_q;
`endif
    if (accept) begin
      ch_cnt_d = push ? '0 : ch_cnt_q + 1'b1;
      for (int k = 0; k < IN_CH - 1; k++) begin
        if (ch_cnt_q == CW'(k)) begin
          stage_d[k*IN_WIDTH +: IN_WIDTH] = in_data;
        end
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = vec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
`ifdef CONV11_INPUT_LAST_EN
      last_d[wr_ptr_q] = beat_last;
`endif
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if ((pix_cnt_q == PIX_LAST) || head_last) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_cnt_q     <= '0;
      stage_q      <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef CONV11_INPUT_LAST_EN
      last_q       <= '0;
`endif
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      stage_q      <= stage_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef CONV11_INPUT_LAST_EN
      last_q       <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv11_input_packer.sv
// Self-checking bench for conv11_input_packer: vector table plus
// a scoreboard queue of expected FIFO outputs and frame_done pulses.
module tb_conv11_input_packer;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int D  = 4;
  localparam int NP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [CH*W-1:0] out_data;
  logic          frame_done, busy;
`ifdef CONV11_INPUT_LAST_EN
  logic          in_last, out_last;
`endif

  conv11_input_packer #(
    .IN_WIDTH(W), .IN_CH(CH), .FIFO_DEPTH(D), .NUM_PIX(NP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef CONV11_INPUT_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct { logic [7:0] lane [4]; logic [31:0] exp; } vec_t;

  exp_t q[$];
  vec_t tab [9];
  int   checks = 0, errors = 0;
  int   pop_cnt = 0, fd_cnt = 0, acc_cnt = 0, pix = 0;
  logic fd_pend = 1'b0;
  bit   mon_on = 1'b0, drv_done = 1'b0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3,
                              input logic [31:0] e);
    vec_t r;
    r.lane[0] = b0; r.lane[1] = b1;
    r.lane[2] = b2; r.lane[3] = b3;
    r.exp = e;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last,
                           input logic [31:0] e, input logic do_push);
    exp_t x;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
`ifdef CONV11_INPUT_LAST_EN
    in_last  = last;
`endif
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready && rst) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout data=%h t=%0t", d, $time);
    end else begin
      acc_cnt++;
      if (do_push) begin
        x.data = e; x.last = last;
        q.push_back(x);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef CONV11_INPUT_LAST_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic send_vec(input int i);
    for (int l = 0; l < 4; l++)
      send_beat(tab[i].lane[l], 1'b0, tab[i].exp, l == 3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain", 32'(q.size() == 0 && !out_valid), 32'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
  endtask

  // Checks the head entry every cycle it is valid; models frame_done.
  always @(negedge clk) begin
    exp_t h;
    if (mon_on) begin
      chk("frame_done", 32'(frame_done), 32'(fd_pend));
      if (frame_done) fd_cnt++;
      fd_pend = 1'b0;
      if (!rst) begin
        pix = 0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid act=%h exp=empty t=%0t",
                   out_data, $time);
        end else begin
          h = q[0];
          chk(out_ready ? "pop_data" : "stall_data", out_data, h.data);
`ifdef CONV11_INPUT_LAST_EN
          chk("out_last", 32'(out_last), 32'(h.last));
`endif
          if (out_ready) begin
            void'(q.pop_front());
            pop_cnt++;
            if (pix == NP - 1 || h.last) begin
              pix = 0; fd_pend = 1'b1;
            end else begin
              pix++;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    tab[0] = mk(8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211);
    tab[1] = mk(8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201);
    tab[2] = mk(8'hde, 8'had, 8'hbe, 8'hef, 32'hefbeadde);
    tab[3] = mk(8'h00, 8'hff, 8'h00, 8'hff, 32'hff00ff00);
    tab[4] = mk(8'h5a, 8'ha5, 8'hc3, 8'h3c, 32'h3cc3a55a);
    tab[5] = mk(8'h80, 8'h7f, 8'h01, 8'hfe, 32'hfe017f80);
    tab[6] = mk(8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412);
    tab[7] = mk(8'h9a, 8'hbc, 8'hde, 8'hf0, 32'hf0debc9a);
    tab[8] = mk(8'ha1, 8'ha2, 8'ha3, 8'ha4, 32'ha4a3a2a1);
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef CONV11_INPUT_LAST_EN
    in_last = 1'b0;
`endif
    reset_dut();

    // Single vector, latency and busy
    out_ready = 1'b1;
    send_beat(8'h11, 1'b0, 32'h0, 1'b0);
    send_beat(8'h22, 1'b0, 32'h0, 1'b0);
    chk("busy_partial", 32'(busy), 32'd1);
    chk("valid_partial", 32'(out_valid), 32'd0);
    send_beat(8'h33, 1'b0, 32'h0, 1'b0);
    send_beat(8'h44, 1'b0, 32'h44332211, 1'b1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'h44332211);
    @(posedge clk); #1;
    chk("after_valid", 32'(out_valid), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);

    // Back-pressure: fill FIFO, block 4th lane of 5th vector
    out_ready = 1'b0;
    acc_cnt = 0; drv_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 5; v++) send_vec(v);
        drv_done = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("stall_accepted", 32'(acc_cnt), 32'd19);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_full_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    for (int i = 0; i < 100 && !drv_done; i++) @(posedge clk);
    #1;
    chk("drv_done", 32'(drv_done), 32'd1);
    wait_drain();

    // Simultaneous push and pop at count 2
    out_ready = 1'b0;
    send_vec(1);
    send_vec(2);
    for (int l = 0; l < 3; l++)
      send_beat(tab[3].lane[l], 1'b0, 32'h0, 1'b0);
    base = pop_cnt;
    out_ready = 1'b1;
    send_beat(tab[3].lane[3], 1'b0, tab[3].exp, 1'b1);
    out_ready = 1'b0;
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_head", out_data, tab[2].exp);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk("pp_pops", 32'(pop_cnt - base), 32'd3);

    // Reset in the middle of a vector
    send_beat(8'hb1, 1'b0, 32'h0, 1'b0);
    send_beat(8'hb2, 1'b0, 32'h0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_dut();
    send_vec(8);
    chk("post_rst_data", out_data, 32'ha4a3a2a1);
    wait_drain();

    // Two frames of continuous traffic
    reset_dut();
    out_ready = 1'b1;
    base = fd_cnt;
    for (int i = 0; i < 8; i++) send_vec(i);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("frame_pulses", 32'(fd_cnt - base), 32'd2);

`ifdef CONV11_INPUT_LAST_EN
    // Early last: zero-filled upper lanes, forced frame end
    base = fd_cnt;
    send_beat(8'h01, 1'b0, 32'h0, 1'b0);
    send_beat(8'h02, 1'b1, 32'h00000201, 1'b1);
    chk("last_valid", 32'(out_valid), 32'd1);
    chk("last_data", out_data, 32'h00000201);
    chk("last_flag", 32'(out_last), 32'd1);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("last_pulse", 32'(fd_cnt - base), 32'd1);
    chk("last_busy", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
